// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and hazard detection beside the ID stage.
// Forwards MEM/WB results to NRP read ports, detects load-use and not-yet-available
// MEM results, tracks in-flight long-latency writers in a busy scoreboard, and
// drives the IF/ID stall, ID/EX flush and a saturating stall-cycle counter.
module fwd_hazard_unit #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  parameter int unsigned NRP  = 2,
  parameter int unsigned CNTW = 32,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [NRP*AW-1:0]   id_ra,
  input  logic [NRP-1:0]      id_re,
  input  logic [NRP*XLEN-1:0] rf_rd,
  input  logic [AW-1:0]       id_wa,
  input  logic                id_we,
  input  logic                id_long,
  input  logic [AW-1:0]       ex_wa,
  input  logic                ex_we,
  input  logic                ex_is_load,
  input  logic [AW-1:0]       mem_wa,
  input  logic                mem_we,
  input  logic [1:0]          mem_wd_sel,
  input  logic [XLEN-1:0]     alu_res_mem,
  input  logic [AW-1:0]       wb_wa,
  input  logic                wb_we,
  input  logic [XLEN-1:0]     rf_wd,
  input  logic                lat_done,
  input  logic [AW-1:0]       lat_wa,
  output logic [NRP*XLEN-1:0] rd_out,
  output logic                stall_if,
  output logic                stall_id,
  output logic                flush_ex,
  output logic [NREG-1:0]     busy_vec,
  output logic [CNTW-1:0]     perf_stall_cnt
);

  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] bypass_vec;
  logic [NREG-1:0] busy_eff;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [NRP-1:0]  port_haz;
  logic            waw_haz;
  logic            stall;
  logic            issue_long;

  // A completing long op whose data is on the WB path this cycle releases its register early.
  always_comb begin
    bypass_vec = '0;
    if (lat_done && wb_we && (lat_wa == wb_wa)) begin
      bypass_vec[lat_wa] = 1'b1;
    end
  end

  assign busy_eff = busy_q & ~bypass_vec;

  for (genvar g = 0; g < NRP; g++) begin : g_port
    logic [AW-1:0] ra;
    logic          ra_nz;
    logic          mem_match;
    logic          mem_fwd;
    logic          mem_nalu;
    logic          wb_fwd;
    logic          ex_load_hit;
    logic          sb_hit;

    assign ra          = id_ra[g*AW +: AW];
    assign ra_nz       = (ra != '0);
    assign mem_match   = ra_nz && mem_we && (ra == mem_wa);
    assign mem_fwd     = mem_match && (mem_wd_sel == 2'b00);
    // Load data or PC-relative result is not produced until WB; cannot forward from MEM.
    assign mem_nalu    = mem_match && (mem_wd_sel != 2'b00);
    assign wb_fwd      = ra_nz && wb_we && (ra == wb_wa);
    assign ex_load_hit = ra_nz && ex_we && ex_is_load && (ra == ex_wa);
    assign sb_hit      = busy_eff[ra];

    // MEM has priority over WB; r0 always reads the register file.
    assign rd_out[g*XLEN +: XLEN] = mem_fwd ? alu_res_mem :
                                    wb_fwd  ? rf_wd       :
                                              rf_rd[g*XLEN +: XLEN];

    // Disabled ports still forward data but never stall.
    assign port_haz[g] = id_re[g] && (ex_load_hit || mem_nalu || sb_hit);
  end

  // Writing a register an older long op still owns would reorder the writes.
  assign waw_haz = id_we && (id_wa != '0) && busy_eff[id_wa];

  assign stall    = (|port_haz) || waw_haz;
  assign stall_if = stall;
  assign stall_id = stall;
  assign flush_ex = stall;

  assign issue_long = id_long && id_we && (id_wa != '0) && !stall;

  // Scoreboard next state: clear first so a same-index issue (younger op) wins.
  always_comb begin
    busy_d = busy_q;
    if (lat_done) begin
      busy_d[lat_wa] = 1'b0;
    end
    if (issue_long) begin
      busy_d[id_wa] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Saturating stall-cycle counter next state.
  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNTW{1'b1}})) begin
      cnt_d = cnt_q + CNTW'(1);
    end
  end

  // Stall-cycle counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_vec       = busy_q;
  assign perf_stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: vector table, directed multi-cycle
// sequences, and random stimulus against a rule-level reference model.
module tb_fwd_hazard_unit;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRP  = 2;
  localparam int AW   = 5;

  logic              clk = 1'b0;
  logic              rstn;
  logic [NRP*AW-1:0] id_ra;
  logic [NRP-1:0]    id_re;
  logic [NRP*XLEN-1:0] rf_rd;
  logic [AW-1:0]     id_wa;
  logic              id_we, id_long;
  logic [AW-1:0]     ex_wa;
  logic              ex_we, ex_is_load;
  logic [AW-1:0]     mem_wa;
  logic              mem_we;
  logic [1:0]        mem_wd_sel;
  logic [XLEN-1:0]   alu_res_mem;
  logic [AW-1:0]     wb_wa;
  logic              wb_we;
  logic [XLEN-1:0]   rf_wd;
  logic              lat_done;
  logic [AW-1:0]     lat_wa;

  logic [NRP*XLEN-1:0] rd_out, rd_out_s;
  logic              stall_if, stall_id, flush_ex;
  logic              stall_if_s, stall_id_s, flush_ex_s;
  logic [NREG-1:0]   busy_vec, busy_vec_s;
  logic [31:0]       perf_cnt;
  logic [3:0]        perf_cnt_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fwd_hazard_unit #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .CNTW(32)) dut (
    .clk(clk), .rstn(rstn), .id_ra(id_ra), .id_re(id_re), .rf_rd(rf_rd),
    .id_wa(id_wa), .id_we(id_we), .id_long(id_long), .ex_wa(ex_wa), .ex_we(ex_we),
    .ex_is_load(ex_is_load), .mem_wa(mem_wa), .mem_we(mem_we), .mem_wd_sel(mem_wd_sel),
    .alu_res_mem(alu_res_mem), .wb_wa(wb_wa), .wb_we(wb_we), .rf_wd(rf_wd),
    .lat_done(lat_done), .lat_wa(lat_wa), .rd_out(rd_out), .stall_if(stall_if),
    .stall_id(stall_id), .flush_ex(flush_ex), .busy_vec(busy_vec),
    .perf_stall_cnt(perf_cnt)
  );

  // Narrow-counter build for the saturation check.
  fwd_hazard_unit #(.XLEN(XLEN), .NREG(NREG), .NRP(NRP), .CNTW(4)) dut_s (
    .clk(clk), .rstn(rstn), .id_ra(id_ra), .id_re(id_re), .rf_rd(rf_rd),
    .id_wa(id_wa), .id_we(id_we), .id_long(id_long), .ex_wa(ex_wa), .ex_we(ex_we),
    .ex_is_load(ex_is_load), .mem_wa(mem_wa), .mem_we(mem_we), .mem_wd_sel(mem_wd_sel),
    .alu_res_mem(alu_res_mem), .wb_wa(wb_wa), .wb_we(wb_we), .rf_wd(rf_wd),
    .lat_done(lat_done), .lat_wa(lat_wa), .rd_out(rd_out_s), .stall_if(stall_if_s),
    .stall_id(stall_id_s), .flush_ex(flush_ex_s), .busy_vec(busy_vec_s),
    .perf_stall_cnt(perf_cnt_s)
  );

  typedef struct packed {
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [1:0]  re;
    logic [4:0]  mwa;
    logic        mwe;
    logic [1:0]  sel;
    logic [4:0]  wwa;
    logic        wwe;
    logic [4:0]  ewa;
    logic        ewe;
    logic        eld;
    logic [31:0] e0;
    logic [31:0] e1;
    logic        es;
  } vec_t;

  vec_t tbl [10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_stall(input string name, input logic exp);
    check(name, {61'd0, stall_if, stall_id, flush_ex}, {61'd0, {3{exp}}});
  endtask

  task automatic clr_inputs();
    id_ra = '0; id_re = '0; rf_rd = {32'h2222_2222, 32'h1111_1111};
    id_wa = '0; id_we = 1'b0; id_long = 1'b0;
    ex_wa = '0; ex_we = 1'b0; ex_is_load = 1'b0;
    mem_wa = '0; mem_we = 1'b0; mem_wd_sel = 2'b00; alu_res_mem = 32'hAAAA_0000;
    wb_wa = '0; wb_we = 1'b0; rf_wd = 32'h0000_1234;
    lat_done = 1'b0; lat_wa = '0;
  endtask

  // Reset pulse aligned so inputs change only on falling edges.
  task automatic do_reset();
    @(negedge clk);
    clr_inputs();
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    #1;
  endtask

  // Reference model state.
  bit          mb [NREG];
  longint      mcnt;

  function automatic bit released(input logic [4:0] r);
    return lat_done && wb_we && (lat_wa == r) && (wb_wa == r);
  endfunction

  task automatic model_check_and_step(input int cyc);
    logic [31:0] exp_rd [NRP];
    logic [NREG-1:0] exp_busy;
    bit hz;
    hz = 0;
    for (int p = 0; p < NRP; p++) begin
      logic [4:0] r;
      r = id_ra[p*AW +: AW];
      if (r != 0 && mem_we && mem_wa == r && mem_wd_sel == 2'b00) exp_rd[p] = alu_res_mem;
      else if (r != 0 && wb_we && wb_wa == r) exp_rd[p] = rf_wd;
      else exp_rd[p] = rf_rd[p*XLEN +: XLEN];
      if (id_re[p] && r != 0) begin
        if (ex_we && ex_is_load && ex_wa == r) hz = 1;
        if (mem_we && mem_wd_sel != 2'b00 && mem_wa == r) hz = 1;
        if (mb[r] && !released(r)) hz = 1;
      end
    end
    if (id_we && id_wa != 0 && mb[id_wa] && !released(id_wa)) hz = 1;
    for (int k = 0; k < NREG; k++) exp_busy[k] = mb[k];
    check($sformatf("rnd%0d rd0", cyc), {32'd0, rd_out[31:0]}, {32'd0, exp_rd[0]});
    check($sformatf("rnd%0d rd1", cyc), {32'd0, rd_out[63:32]}, {32'd0, exp_rd[1]});
    check_stall($sformatf("rnd%0d stall", cyc), hz);
    check($sformatf("rnd%0d busy", cyc), {32'd0, busy_vec}, {32'd0, exp_busy});
    check($sformatf("rnd%0d cnt", cyc), {32'd0, perf_cnt}, mcnt);
    // Effects of the coming rising edge.
    if (lat_done) mb[lat_wa] = 0;
    if (id_long && id_we && id_wa != 0 && !hz) mb[id_wa] = 1;
    mb[0] = 0;
    if (hz && mcnt != 64'hFFFF_FFFF) mcnt++;
  endtask

  initial begin
    rstn = 1'b0;
    clr_inputs();
    repeat (2) @(negedge clk);
    #1;
    check("reset busy", {32'd0, busy_vec}, 64'd0);
    check("reset cnt", {32'd0, perf_cnt}, 64'd0);
    check_stall("reset stall", 1'b0);
    rstn = 1'b1;

    // Combinational forwarding/hazard vectors, empty scoreboard.
    tbl[0] = '{5'd5, 5'd6, 2'b11, 5'd5, 1'b1, 2'b00, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0,
               32'hAAAA_0000, 32'h2222_2222, 1'b0};
    tbl[1] = '{5'd0, 5'd0, 2'b11, 5'd0, 1'b1, 2'b00, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1,
               32'h1111_1111, 32'h2222_2222, 1'b0};
    tbl[2] = '{5'd3, 5'd4, 2'b11, 5'd3, 1'b0, 2'b00, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0,
               32'h1111_1111, 32'h0000_1234, 1'b0};
    tbl[3] = '{5'd8, 5'd8, 2'b01, 5'd8, 1'b1, 2'b01, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0,
               32'h1111_1111, 32'h2222_2222, 1'b1};
    tbl[4] = '{5'd8, 5'd8, 2'b00, 5'd8, 1'b1, 2'b01, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0,
               32'h1111_1111, 32'h2222_2222, 1'b0};
    tbl[5] = '{5'd1, 5'd9, 2'b10, 5'd0, 1'b0, 2'b00, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1,
               32'h1111_1111, 32'h2222_2222, 1'b1};
    tbl[6] = '{5'd1, 5'd9, 2'b10, 5'd0, 1'b0, 2'b00, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0,
               32'h1111_1111, 32'h2222_2222, 1'b0};
    tbl[7] = '{5'd9, 5'd9, 2'b00, 5'd0, 1'b0, 2'b00, 5'd9, 1'b1, 5'd9, 1'b1, 1'b1,
               32'h0000_1234, 32'h0000_1234, 1'b0};
    tbl[8] = '{5'd2, 5'd0, 2'b01, 5'd2, 1'b1, 2'b10, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0,
               32'h0000_1234, 32'h2222_2222, 1'b1};
    tbl[9] = '{5'd9, 5'd0, 2'b01, 5'd0, 1'b0, 2'b00, 5'd0, 1'b0, 5'd9, 1'b0, 1'b1,
               32'h1111_1111, 32'h2222_2222, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      clr_inputs();
      id_ra = {tbl[i].ra1, tbl[i].ra0}; id_re = tbl[i].re;
      mem_wa = tbl[i].mwa; mem_we = tbl[i].mwe; mem_wd_sel = tbl[i].sel;
      wb_wa = tbl[i].wwa; wb_we = tbl[i].wwe;
      ex_wa = tbl[i].ewa; ex_we = tbl[i].ewe; ex_is_load = tbl[i].eld;
      #1;
      check($sformatf("vec%0d rd0", i), {32'd0, rd_out[31:0]}, {32'd0, tbl[i].e0});
      check($sformatf("vec%0d rd1", i), {32'd0, rd_out[63:32]}, {32'd0, tbl[i].e1});
      check_stall($sformatf("vec%0d stall", i), tbl[i].es);
    end

    // Load-use: EX load, then MEM non-ALU, then WB forward.
    do_reset();
    id_ra = {5'd7, 5'd0}; id_re = 2'b10;
    ex_wa = 5'd7; ex_we = 1'b1; ex_is_load = 1'b1;
    #1; check_stall("lu ex", 1'b1);
    @(negedge clk);
    ex_we = 1'b0; ex_is_load = 1'b0;
    mem_wa = 5'd7; mem_we = 1'b1; mem_wd_sel = 2'b01;
    #1; check_stall("lu mem", 1'b1);
    @(negedge clk);
    mem_we = 1'b0; mem_wd_sel = 2'b00;
    wb_wa = 5'd7; wb_we = 1'b1; rf_wd = 32'hCAFE_0007;
    #1;
    check_stall("lu wb", 1'b0);
    check("lu wb rd1", {32'd0, rd_out[63:32]}, 64'hCAFE_0007);
    @(negedge clk); #1;
    check("lu cnt", {32'd0, perf_cnt}, 64'd2);

    // Long op to r9, read it while busy, then same-cycle WB release.
    do_reset();
    id_wa = 5'd9; id_we = 1'b1; id_long = 1'b1;
    #1; check_stall("long issue", 1'b0);
    @(negedge clk);
    id_we = 1'b0; id_long = 1'b0;
    id_ra = {5'd0, 5'd9}; id_re = 2'b01;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_stall($sformatf("long busy%0d stall", i), 1'b1);
      check($sformatf("long busy%0d bit", i), {63'd0, busy_vec[9]}, 64'd1);
      @(negedge clk);
    end
    lat_done = 1'b1; lat_wa = 5'd9; wb_we = 1'b1; wb_wa = 5'd9; rf_wd = 32'h0000_BEEF;
    #1;
    check_stall("long done stall", 1'b0);
    check("long done rd0", {32'd0, rd_out[31:0]}, 64'hBEEF);
    @(negedge clk);
    clr_inputs();
    #1;
    check("long cleared", {63'd0, busy_vec[9]}, 64'd0);
    check("long cnt", {32'd0, perf_cnt}, 64'd4);

    // Same-cycle clear and re-issue to r3: set wins.
    do_reset();
    id_wa = 5'd3; id_we = 1'b1; id_long = 1'b1;
    @(negedge clk);
    lat_done = 1'b1; lat_wa = 5'd3; wb_we = 1'b1; wb_wa = 5'd3;
    #1; check_stall("r3 reissue stall", 1'b0);
    @(negedge clk);
    clr_inputs();
    #1;
    check("r3 set wins", {63'd0, busy_vec[3]}, 64'd1);

    // Saturation of the 4-bit counter, then asynchronous reset mid-stall.
    do_reset();
    id_wa = 5'd4; id_we = 1'b1; id_long = 1'b1;
    @(negedge clk);
    clr_inputs();
    id_ra = {5'd0, 5'd4}; id_re = 2'b01;
    for (int i = 0; i < 20; i++) @(negedge clk);
    #1;
    check_stall("sat stall held", 1'b1);
    check("sat cnt4", {60'd0, perf_cnt_s}, 64'hF);
    check("sat cnt32", {32'd0, perf_cnt}, 64'd20);
    rstn = 1'b0;
    #1;
    check("arst busy", {32'd0, busy_vec}, 64'd0);
    check("arst cnt32", {32'd0, perf_cnt}, 64'd0);
    check("arst cnt4", {60'd0, perf_cnt_s}, 64'd0);
    check_stall("arst stall", 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk); #1;
    check_stall("post rst stall", 1'b0);
    check("post rst cnt", {32'd0, perf_cnt}, 64'd0);

    // Random stimulus against the reference model.
    do_reset();
    for (int k = 0; k < NREG; k++) mb[k] = 0;
    mcnt = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      id_ra = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      id_re = 2'($urandom);
      rf_rd = {$urandom, $urandom};
      id_wa = 5'($urandom_range(0, 7));
      id_we = ($urandom_range(0, 2) != 0);
      id_long = ($urandom_range(0, 2) == 0);
      ex_wa = 5'($urandom_range(0, 7)); ex_we = 1'($urandom); ex_is_load = 1'($urandom);
      mem_wa = 5'($urandom_range(0, 7)); mem_we = 1'($urandom);
      mem_wd_sel = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      alu_res_mem = $urandom;
      wb_wa = 5'($urandom_range(0, 7)); wb_we = 1'($urandom); rf_wd = $urandom;
      lat_done = ($urandom_range(0, 2) == 0);
      lat_wa = 5'($urandom_range(0, 7));
      if (lat_done && $urandom_range(0, 1) == 1) begin
        wb_we = 1'b1; wb_wa = lat_wa;
      end
      #1;
      model_check_and_step(c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
